// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target: FSM state encoding, default bus
// address and the bus-level ACK/NACK values.
package i2c_pkg;

  localparam logic [6:0] I2C_DEFAULT_ADDR = 7'b1101001;
  localparam logic       I2C_ACK          = 1'b0;
  localparam logic       I2C_NACK         = 1'b1;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    REG,
    REG_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } i2c_state_t;

endpackage

// File: rtl/i2c_sync_edge.sv
// Brings the asynchronous SCL/SDA pins into the clk domain and decodes the bus
// events (SCL edges, START, STOP) from the synchronized level and one history flop.
module i2c_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda_s,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [1:0] scl_sync;
  logic [1:0] sda_sync;
  logic       scl_hist;
  logic       sda_hist;

  // Idle bus is high, so reset to 1 to avoid a phantom edge when leaving reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_in};
      sda_sync <= {sda_sync[0], sda_in};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_sync[1] & ~scl_hist;
  assign scl_fall = ~scl_sync[1] & scl_hist;
  assign start    = scl_sync[1] & scl_hist & sda_hist & ~sda_sync[1];
  assign stop     = scl_sync[1] & scl_hist & ~sda_hist & sda_sync[1];

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target with a 2**REG_AW-byte register file, open-drain SDA drive and a write strobe.
// Define I2C_SLAVE_AUTOINC_EN to advance the register pointer after each acked byte.
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = I2C_DEFAULT_ADDR,
  parameter int         REG_AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_in,
  input  logic              sda_in,
  output logic              sda_oe,
  output logic              busy,
  output logic              wr_valid,
  output logic [REG_AW-1:0] wr_addr,
  output logic [7:0]        wr_data
);

  // state     | meaning
  // IDLE      | bus free, nothing addressed
  // ADDR      | shifting in the address byte
  // ADDR_ACK  | driving ACK for our address
  // REG       | shifting in the register pointer byte
  // REG_ACK   | driving ACK for the pointer byte
  // WDATA     | shifting in a write data byte
  // WDATA_ACK | driving ACK for a write data byte
  // RDATA     | shifting out reg[ptr]
  // RDATA_ACK | SDA released, sampling the master's ACK/NACK
  // WAIT_STOP | not addressed or read ended, ignore bits until START/STOP

  localparam int DEPTH = 2 ** REG_AW;

  i2c_state_t        state, state_d;
  logic              sda_s, scl_rise, scl_fall, start, stop;
  logic [3:0]        bit_cnt, cnt_d;
  logic [7:0]        shreg, shreg_d;
  logic [REG_AW-1:0] ptr, ptr_d, ptr_adv;
  logic [7:0]        regs [DEPTH];
  logic [7:0]        rd_byte;
  logic              sda_oe_d, busy_d, wr_en, addr_hit;

  i2c_sync_edge u_sync (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda_s    (sda_s),
    .scl_rise (scl_rise),
    .scl_fall (scl_fall),
    .start    (start),
    .stop     (stop)
  );

`ifdef I2C_SLAVE_AUTOINC_EN
  assign ptr_adv = ptr + REG_AW'(1);
`else
  assign ptr_adv = ptr;
`endif

  assign rd_byte  = regs[ptr];
  assign addr_hit = (shreg[7:1] == SLAVE_ADDR);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (stop) begin
      state_d = IDLE;
    end else if (start) begin
      state_d = ADDR;
    end else begin
      case (state)
        ADDR:      if (scl_fall && bit_cnt == 4'd8) state_d = addr_hit ? ADDR_ACK : WAIT_STOP;
        REG:       if (scl_fall && bit_cnt == 4'd8) state_d = REG_ACK;
        WDATA:     if (scl_fall && bit_cnt == 4'd8) state_d = WDATA_ACK;
        ADDR_ACK:  if (scl_fall) state_d = shreg[0] ? RDATA : REG;
        REG_ACK,
        WDATA_ACK: if (scl_fall) state_d = WDATA;
        RDATA:     if (scl_fall && bit_cnt == 4'd8) state_d = RDATA_ACK;
        RDATA_ACK: begin
          if (scl_rise && sda_s == I2C_NACK)       state_d = WAIT_STOP;
          else if (scl_fall && bit_cnt == 4'd9)    state_d = RDATA;
        end
        default: ;
      endcase
    end
  end

  // Datapath next values; the read byte's MSB goes out on the same fall that ends the ACK.
  always_comb begin
    sda_oe_d = sda_oe;
    busy_d   = busy;
    cnt_d    = bit_cnt;
    shreg_d  = shreg;
    ptr_d    = ptr;
    wr_en    = 1'b0;
    if (stop) begin
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else if (start) begin
      sda_oe_d = 1'b0;
      cnt_d    = 4'd0;
    end else begin
      case (state)
        ADDR, REG, WDATA: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_d = {shreg[6:0], sda_s};
            cnt_d   = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            cnt_d = 4'd0;
            if (state == ADDR) begin
              sda_oe_d = addr_hit;
              busy_d   = addr_hit;
            end else if (state == REG) begin
              sda_oe_d = 1'b1;
              ptr_d    = shreg[REG_AW-1:0];
            end else begin
              sda_oe_d = 1'b1;
              wr_en    = 1'b1;
              ptr_d    = ptr_adv;
            end
          end
        end
        ADDR_ACK, REG_ACK, WDATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d = 1'b0;
            cnt_d    = 4'd0;
            if (state == ADDR_ACK && shreg[0]) begin
              shreg_d  = rd_byte;
              sda_oe_d = ~rd_byte[7];
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_oe_d = 1'b0;
            end else begin
              shreg_d  = {shreg[6:0], 1'b0};
              sda_oe_d = ~shreg[6];
            end
          end
        end
        RDATA_ACK: begin
          if (scl_rise) begin
            if (sda_s == I2C_ACK) begin
              ptr_d = ptr_adv;
              cnt_d = 4'd9;
            end else begin
              busy_d = 1'b0;
            end
          end else if (scl_fall && bit_cnt == 4'd9) begin
            shreg_d  = rd_byte;
            sda_oe_d = ~rd_byte[7];
            cnt_d    = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sda_oe   <= 1'b0;
      busy     <= 1'b0;
      bit_cnt  <= 4'd0;
      shreg    <= 8'd0;
      ptr      <= '0;
      wr_valid <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= 8'd0;
      for (int i = 0; i < DEPTH; i++) regs[i] <= 8'd0;
    end else begin
      sda_oe   <= sda_oe_d;
      busy     <= busy_d;
      bit_cnt  <= cnt_d;
      shreg    <= shreg_d;
      ptr      <= ptr_d;
      wr_valid <= wr_en;
      if (wr_en) begin
        regs[ptr] <= shreg;
        wr_addr   <= ptr;
        wr_data   <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Bench for i2c_slave_regs: acts as bus master and checks against a transaction-level model.
module tb_i2c_slave_regs;

  localparam logic [6:0] SLV = 7'h69;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, busy, wr_valid;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       sda_bus;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_slave_regs dut (
    .clk      (clk),
    .reset    (reset),
    .scl_in   (scl_m),
    .sda_in   (sda_bus),
    .sda_oe   (sda_oe),
    .busy     (busy),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Transaction-level model
  logic [7:0] mdl_regs [16];
  logic [3:0] mdl_ptr;
  bit         exp_busy;
  int         exp_wa[$];
  int         exp_wd[$];
  int         obs_addr[$];
  int         obs_data[$];

  function automatic logic [3:0] adv(input logic [3:0] p);
    return AUTOINC ? p + 4'd1 : p;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < 16; i++) mdl_regs[i] = 8'h00;
    mdl_ptr  = 4'h0;
    exp_busy = 1'b0;
  endtask

  // Every write strobe must match the next expected write and coincide with the ACK drive.
  always @(negedge clk) begin
    if (!reset && wr_valid) begin
      obs_addr.push_back(int'(wr_addr));
      obs_data.push_back(int'(wr_data));
      if (exp_wa.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL wr_unexpected: got addr %0h data %0h expected no write", wr_addr, wr_data);
      end else begin
        check("wr_addr", wr_addr, exp_wa.pop_front());
        check("wr_data", wr_data, exp_wd.pop_front());
        check("wr_ack_align", sda_oe, 1);
      end
    end
  end

  task automatic i2c_start();
    clks(5); sda_m = 1'b1; clks(5); scl_m = 1'b1;
    clks(10); sda_m = 1'b0; clks(10); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    clks(5); sda_m = 1'b0; clks(5); scl_m = 1'b1;
    clks(10); sda_m = 1'b1; clks(10);
    exp_busy = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_oe", sda_oe, 0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      clks(5); sda_m = b[i]; clks(5); scl_m = 1'b1; clks(6);
      check("tx_bit_oe", sda_oe, 0);
      check("tx_bit_busy", busy, exp_busy);
      clks(4); scl_m = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit ack_exp, input bit busy_after);
    send_bits(b, 8);
    exp_busy = busy_after;
    clks(5); sda_m = 1'b1; clks(5); scl_m = 1'b1; clks(6);
    check("ack_slot", sda_oe, ack_exp);
    check("ack_busy", busy, exp_busy);
    clks(4); scl_m = 1'b0;
  endtask

  task automatic recv_byte(input logic [7:0] exp, input bit m_ack, output logic [7:0] got);
    got = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      clks(5); sda_m = 1'b1; clks(5); scl_m = 1'b1; clks(6);
      got[i] = sda_bus;
      check("rd_busy", busy, exp_busy);
      clks(4); scl_m = 1'b0;
    end
    check("rd_byte", got, exp);
    clks(5); sda_m = m_ack ? 1'b0 : 1'b1; clks(5); scl_m = 1'b1; clks(6);
    check("rd_mack_release", sda_oe, 0);
    clks(4); scl_m = 1'b0;
    if (!m_ack) exp_busy = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] regb, input logic [7:0] d0, input logic [7:0] d1,
                          input logic [7:0] d2, input int n);
    logic [7:0] d [3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    i2c_start();
    send_byte({SLV, 1'b0}, 1'b1, 1'b1);
    send_byte(regb, 1'b1, 1'b1);
    mdl_ptr = regb[3:0];
    for (int i = 0; i < n; i++) begin
      exp_wa.push_back(int'(mdl_ptr));
      exp_wd.push_back(int'(d[i]));
      mdl_regs[mdl_ptr] = d[i];
      send_byte(d[i], 1'b1, 1'b1);
      mdl_ptr = adv(mdl_ptr);
    end
    i2c_stop();
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] regb, input int n,
                         output logic [7:0] last);
    i2c_start();
    if (set_ptr) begin
      send_byte({SLV, 1'b0}, 1'b1, 1'b1);
      send_byte(regb, 1'b1, 1'b1);
      mdl_ptr = regb[3:0];
      i2c_start();
    end
    send_byte({SLV, 1'b1}, 1'b1, 1'b1);
    for (int i = 0; i < n; i++) begin
      recv_byte(mdl_regs[mdl_ptr], i != n - 1, last);
      if (i != n - 1) mdl_ptr = adv(mdl_ptr);
    end
    i2c_stop();
  endtask

  task automatic do_wrong(input logic [6:0] a, input bit rw, input logic [7:0] b);
    i2c_start();
    send_byte({a, rw}, 1'b0, 1'b0);
    send_byte(b, 1'b0, 1'b0);
    i2c_stop();
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [7:0] got;
    logic [6:0] wa;
    int         nobs;
    mdl_reset();
    clks(4);
    check("rst_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_valid", wr_valid, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    reset = 1'b0;
    clks(10);

    // Plain write, then read it back through a repeated START
    do_write(8'hFB, 8'hAA, 8'h00, 8'h00, 1);
    check("w1_count", obs_addr.size(), 1);
    if (obs_addr.size() >= 1) begin
      check("w1_addr_lit", obs_addr[0], 32'hB);
      check("w1_data_lit", obs_data[0], 32'hAA);
    end
    do_read(1'b1, 8'h0B, 1, got);
    check("rb_lit", got, 8'hAA);

    // Foreign address stays silent
    do_wrong(7'h50, 1'b0, 8'h5A);
    check("wrong_no_write", obs_addr.size(), 1);

    // Burst write across the pointer wrap
    do_write(8'h0F, 8'h11, 8'h22, 8'h00, 2);
    check("burst_count", obs_addr.size(), 3);
    if (obs_addr.size() >= 3) begin
      check("burst_addr0_lit", obs_addr[1], 32'hF);
      check("burst_addr1_lit", obs_addr[2], AUTOINC ? 32'h0 : 32'hF);
    end

    // STOP in the middle of the pointer byte leaves ptr alone and writes nothing
    nobs = obs_addr.size();
    i2c_start();
    send_byte({SLV, 1'b0}, 1'b1, 1'b1);
    send_bits(8'hF5, 4);
    i2c_stop();
    check("stop_reg_no_write", obs_addr.size(), nobs);
    do_read(1'b0, 8'h00, 1, got);

    // Reset while driving a read bit low
    do_write(8'h0B, 8'h3C, 8'h00, 8'h00, 1);
    i2c_start();
    send_byte({SLV, 1'b0}, 1'b1, 1'b1);
    send_byte(8'h0B, 1'b1, 1'b1);
    mdl_ptr = 4'hB;
    i2c_start();
    send_byte({SLV, 1'b1}, 1'b1, 1'b1);
    clks(5);
    check("rst_mid_pre_oe", sda_oe, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_oe", sda_oe, 0);
    check("rst_mid_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    mdl_reset();
    i2c_stop();
    do_read(1'b1, 8'h0B, 1, got);
    check("rst_read_lit", got, 8'h00);

    // Randomized traffic
    for (int t = 0; t < 25; t++) begin
      case ($urandom_range(3))
        0: do_write(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), $urandom_range(1, 3));
        1: do_read(1'b1, 8'($urandom), $urandom_range(1, 3), got);
        2: do_read(1'b0, 8'h00, $urandom_range(1, 3), got);
        default: begin
          wa = 7'($urandom);
          if (wa == SLV) wa = wa ^ 7'h01;
          do_wrong(wa, 1'($urandom), 8'($urandom));
        end
      endcase
    end

    clks(10);
    check("writes_drained", exp_wa.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/i2c_slave_regs.md
# i2c_slave_regs

I2C target (responder) with an on-chip byte register file; the counterpart of the team's `I2C_master1` initiator on the same bus. It oversamples `scl`/`sda` on the system clock and decodes START/STOP, the 7-bit address, the register pointer byte and data bytes. It drives ACKs and read data onto SDA as an open-drain pull-down, and reports every accepted write to local logic.

## Interface
- `SLAVE_ADDR`, default 7'b1101001: 7-bit bus address this target answers to.
- `REG_AW`, default 4: register-file address width; file depth is 2**REG_AW bytes.
- `clk` in 1: system clock; all logic is in this domain.
- `reset` in 1: synchronous, active-high reset.
- `scl_in` in 1: bus SCL, asynchronous.
- `sda_in` in 1: bus SDA, asynchronous.
- `sda_oe` out 1: 1 = pull SDA low, 0 = release; reset 0.
- `busy` out 1: addressed transaction in progress, from address match to STOP or NACK exit; reset 0.
- `wr_valid` out 1: one-clk pulse per accepted write byte; reset 0.
- `wr_addr` out REG_AW: register written; reset 0.
- `wr_data` out 8: byte written; reset 0.

## Operation
- Input conditioning: both pins pass through a 2-flop synchronizer plus one history flop. The following events are derived on the synchronized signals:
  - `scl_rise` and `scl_fall`.
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
- States: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, WAIT_STOP.
- START from any state goes to ADDR and clears the bit counter. This also handles repeated START.
- STOP from any state goes to IDLE, releases SDA and deasserts `busy`.
- START and STOP take priority over any bit event in the same clk.
- Bits are sampled on `scl_rise`, MSB first.
- ADDR: after 8 bits, compare bits[7:1] against SLAVE_ADDR.
  - Match: go to ADDR_ACK and assert `busy`.
  - Mismatch: go to WAIT_STOP without driving SDA. A later START still re-enters ADDR.
- ADDR_ACK:
  - R/W=0 (write): go to REG.
  - R/W=1 (read): go to RDATA, reading reg[ptr].
- REG: after 8 bits, load ptr with the low REG_AW bits of the byte (upper bits ignored), then go to REG_ACK and on to WDATA.
- WDATA: after 8 bits, write the byte to reg[ptr] and pulse `wr_valid` with `wr_addr`=ptr and `wr_data`=byte. Go to WDATA_ACK, then back to WDATA.
- RDATA: shift out reg[ptr]. On the 9th `scl_rise`, sample the master's response:
  - SDA=0 (ACK): advance ptr, then continue in RDATA.
  - SDA=1 (NACK): go to WAIT_STOP.
- Register file resets to all zeros. It is written only over I2C.

## Timing
- Event latency: 3 clk from pin change to START/STOP/edge decode.
- Minimum SCL high and low times: 8 clk each. No clock stretching.
- Target ACK:
  - `sda_oe`=1 is asserted on the `scl_fall` that ends bit 8.
  - It is held through the 9th SCL high.
  - It is released on the 9th `scl_fall`.
- `wr_valid` fires in the same clk that the ACK `sda_oe` rises.
- Read data:
  - Bit 7 is driven on the `scl_fall` ending the ACK.
  - Each following bit is driven on the next `scl_fall`.
  - SDA is released (`sda_oe`=0) for the master's ACK slot after the 8th bit's fall.
  - Data value 1 means `sda_oe`=0.
- Pointer wrap: ptr increments modulo 2**REG_AW, so 2**REG_AW-1 goes to 0.
- Reset mid-transaction: the next clk has `sda_oe`=0, state IDLE, ptr 0, and registers cleared.

## Configuration
- `I2C_SLAVE_AUTOINC_EN` defined: ptr increments after each ACKed write byte and each master-ACKed read byte, enabling bursts.
- Not defined: ptr stays fixed. Burst writes overwrite the same register and burst reads repeat the same byte.

## Structure
- Package `i2c_pkg`:
  - State enum.
  - Default address constant 7'b1101001.
  - `I2C_ACK`=1'b0 and `I2C_NACK`=1'b1 constants.
- Sub-module `i2c_sync_edge`: synchronizers, history flops, and `scl_rise`/`scl_fall`/`start`/`stop` outputs.
- FSM, shifter, ptr and register file live in the top module.

## Test plan
- Write: START, address byte 0xD2, reg byte 0xFB, data 0xAA, STOP.
  - Response: 3 ACKs (`sda_oe`=1 in slot 9 each time).
  - One `wr_valid` with `wr_addr`=0xB, `wr_data`=0xAA.
  - `busy` falls at STOP.
- Read-back: START, 0xD2, reg byte 0x0B, repeated START, 0xD3, then one byte with master NACK.
  - Response: data byte 0xAA is shifted out, then WAIT_STOP.
  - `sda_oe`=0 in the master ACK slot.
- Wrong address: START, 0xA0.
  - Response: `sda_oe` stays 0 for the whole transfer, no `busy`, no `wr_valid`.
- Burst with AUTOINC: write reg 0x0F, data 0x11, 0x22.
  - Response: `wr_addr` 0xF then 0x0 (wrap).
  - Without the macro: `wr_addr` 0xF twice.
- Reset mid-byte during RDATA with `sda_oe`=1.
  - Response: `sda_oe`=0 on the next clk.
  - A subsequent read of reg 0xB returns 0x00.
- STOP during REG byte (after 4 bits).
  - Response: IDLE, `busy`=0, ptr unchanged, no write.
